keypad_scan: RTL and testbench

KEYPAD_SCAN -- requirements
Module: keypad_scan

---
 rtl/keypad_pkg.sv | 23 ++
 rtl/decode2.sv | 9 +
 rtl/keypad_scan.sv | 161 ++++++++++++++++
 tb/tb_keypad_scan.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } state_t;

  localparam int SCAN_DIV_DEFAULT       = 1000;
  localparam int DEBOUNCE_SCANS_DEFAULT = 3;
  localparam logic [3:0] ROWS_IDLE      = 4'b1111;

  // Rows are active-low, so the first zero bit from index 0 up is the winner.
  function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
    if (!rows[0])      return 2'd0;
    else if (!rows[1]) return 2'd1;
    else if (!rows[2]) return 2'd2;
    else               return 2'd3;
  endfunction

endpackage

// File: rtl/decode2.sv
// 2-bit index to 4-bit one-hot-low decoder for the keypad column drive.
module decode2 (
  input  logic [1:0] idx,
  output logic [3:0] onehot_low
);

  assign onehot_low = ~(4'b0001 << idx);

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: column scan, row synchronizer, press/release debounce.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = SCAN_DIV_DEFAULT,
  parameter int DEBOUNCE_SCANS = DEBOUNCE_SCANS_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int CNT_W   = $clog2(SCAN_DIV);
  localparam int MATCH_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST     = CNT_W'(SCAN_DIV - 1);
  localparam logic [MATCH_W-1:0] MATCH_TARGET = MATCH_W'(DEBOUNCE_SCANS);
  localparam logic [MATCH_W-1:0] MATCH_ONE    = MATCH_W'(1);

  logic [3:0]         row_meta, row_sync;
  logic [CNT_W-1:0]   period_cnt;
  logic               sample, row_low;

  state_t             state, state_next;
  logic [1:0]         col_idx, col_idx_next;
  logic [1:0]         row_idx, row_idx_next;
  logic [3:0]         row_pat, row_pat_next;
  logic [MATCH_W-1:0] match_cnt, match_next, match_inc;
  logic [3:0]         key_code_next;
  logic               key_valid_next, key_held_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_meta <= ROWS_IDLE;
      row_sync <= ROWS_IDLE;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  // Sampling on the last count of each period gives the columns time to settle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       period_cnt <= '0;
    else if (sample) period_cnt <= '0;
    else             period_cnt <= period_cnt + 1'b1;
  end

  assign sample    = (period_cnt == CNT_LAST);
  assign row_low   = (row_sync != ROWS_IDLE);
  assign match_inc = (match_cnt == MATCH_TARGET) ? match_cnt : match_cnt + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_SCAN;
      col_idx   <= 2'd0;
      row_idx   <= 2'd0;
      row_pat   <= ROWS_IDLE;
      match_cnt <= '0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_next;
      col_idx   <= col_idx_next;
      row_idx   <= row_idx_next;
      row_pat   <= row_pat_next;
      match_cnt <= match_next;
      key_code  <= key_code_next;
      key_valid <= key_valid_next;
      key_held  <= key_held_next;
    end
  end

  always_comb begin
    state_next     = state;
    col_idx_next   = col_idx;
    row_idx_next   = row_idx;
    row_pat_next   = row_pat;
    match_next     = match_cnt;
    key_code_next  = key_code;
    key_valid_next = 1'b0;
    key_held_next  = key_held;

    if (sample) begin
      case (state)
        ST_SCAN: begin
          if (row_low) begin
            row_idx_next = lowest_low_row(row_sync);
            row_pat_next = row_sync;
            match_next   = MATCH_ONE;
            if (DEBOUNCE_SCANS == 1) begin
              key_code_next  = {lowest_low_row(row_sync), col_idx};
              key_valid_next = 1'b1;
              key_held_next  = 1'b1;
              state_next     = ST_HELD;
            end else begin
              state_next = ST_DEBOUNCE;
            end
          end else begin
            col_idx_next = col_idx + 2'd1;
          end
        end

        ST_DEBOUNCE: begin
          if (row_sync == row_pat) begin
            match_next = match_inc;
            if (match_inc == MATCH_TARGET) begin
              key_code_next  = {row_idx, col_idx};
              key_valid_next = 1'b1;
              key_held_next  = 1'b1;
              state_next     = ST_HELD;
            end
          end else begin
            match_next   = '0;
            col_idx_next = col_idx + 2'd1;
            state_next   = ST_SCAN;
          end
        end

        // Extra keys only matter through row_low; the frozen column hides most of them.
        ST_HELD: begin
          if (!row_low) begin
            match_next = MATCH_ONE;
            if (DEBOUNCE_SCANS == 1) begin
              key_held_next = 1'b0;
              col_idx_next  = col_idx + 2'd1;
              state_next    = ST_SCAN;
            end else begin
              state_next = ST_RELEASE;
            end
          end
        end

        ST_RELEASE: begin
          if (!row_low) begin
            match_next = match_inc;
            if (match_inc == MATCH_TARGET) begin
              key_held_next = 1'b0;
              col_idx_next  = col_idx + 2'd1;
              state_next    = ST_SCAN;
            end
          end else begin
            state_next = ST_HELD;
          end
        end

        default: state_next = ST_SCAN;
      endcase
    end
  end

  decode2 u_col_decode (
    .idx        (col_idx),
    .onehot_low (col)
  );

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a 4x4 switch-matrix model driving the rows.
module tb_keypad_scan;

  localparam int SCAN_DIV       = 4;
  localparam int DEBOUNCE_SCANS = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  row, col, key_code;
  logic        key_valid, key_held;
  logic [15:0] pressed;
  logic [3:0]  col_tab [4];

  int compared   = 0;
  int mismatched = 0;
  int valid_cnt  = 0;
  int cyc        = 0;

  keypad_scan #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // A pressed switch at (r,c) pulls row r low whenever column c is driven low.
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (key_valid) valid_cnt <= valid_cnt + 1;
  end

  task checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task applyStimulus(input logic [15:0] keys);
    pressed = keys;
  endtask

  task next_cycle;
    @(negedge clk);
    #1;
  endtask

  // Sample edges are the posedges whose count since reset release is a multiple of 4.
  task next_sample;
    do next_cycle(); while (cyc % SCAN_DIV != 0);
  endtask

  task wait_col(input logic [3:0] want, input string tag);
    int k;
    k = 0;
    while (col !== want && k < 8) begin
      next_sample();
      k++;
    end
    checkOutput(tag, col, want);
  endtask

  task wait_valid(input string tag);
    int k;
    k = 0;
    while (key_valid !== 1'b1 && k < 40) begin
      next_cycle();
      k++;
    end
    checkOutput(tag, key_valid, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    col_tab[0] = 4'b1110;
    col_tab[1] = 4'b1101;
    col_tab[2] = 4'b1011;
    col_tab[3] = 4'b0111;
    applyStimulus(16'h0000);
    reset = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_col", col, 4'b1110);
    checkOutput("reset_code", key_code, 0);
    checkOutput("reset_valid", key_valid, 0);
    checkOutput("reset_held", key_held, 0);

    @(negedge clk);
    reset = 1'b0;

    // Idle scan: column index after posedge n is (n/4)%4.
    for (int n = 1; n <= 40; n++) begin
      next_cycle();
      if (n % 4 == 2) checkOutput("idle_col", col, col_tab[(n/4)%4]);
    end
    checkOutput("idle_no_valid", valid_cnt, 0);

    // Two rows low on column 0: row 0 wins, then extra keys while held are ignored.
    wait_col(col_tab[0], "multi_reach_col0");
    applyStimulus(16'h0101);
    next_sample();
    next_sample();
    checkOutput("multi_early_valid", valid_cnt, 0);
    next_sample();
    checkOutput("multi_valid_pulse", key_valid, 1);
    checkOutput("multi_code", key_code, 0);
    checkOutput("multi_held", key_held, 1);
    next_cycle();
    checkOutput("multi_valid_one_cycle", key_valid, 0);
    applyStimulus(16'h0131);
    repeat (3) next_sample();
    checkOutput("multi_extra_no_valid", valid_cnt, 1);
    checkOutput("multi_extra_held", key_held, 1);
    checkOutput("multi_extra_col", col, col_tab[0]);
    applyStimulus(16'h0000);
    repeat (3) next_sample();
    checkOutput("multi_release_held", key_held, 0);
    checkOutput("multi_release_col", col, col_tab[1]);

    // Clean press of row 1 / column 2.
    wait_col(col_tab[2], "press_reach_col2");
    applyStimulus(16'h0040);
    wait_valid("press_valid");
    checkOutput("press_code", key_code, 6);
    checkOutput("press_held", key_held, 1);
    checkOutput("press_col_frozen", col, col_tab[2]);
    repeat (20) next_cycle();
    checkOutput("press_single_valid", valid_cnt, 2);
    checkOutput("press_col_still", col, col_tab[2]);

    // Release with a one-sample re-bounce back to pressed.
    applyStimulus(16'h0000);
    next_sample();
    applyStimulus(16'h0040);
    next_sample();
    checkOutput("rebounce_held", key_held, 1);
    applyStimulus(16'h0000);
    next_sample();
    next_sample();
    checkOutput("release_held_2of3", key_held, 1);
    next_sample();
    checkOutput("release_held_clear", key_held, 0);
    checkOutput("release_col_next", col, col_tab[3]);
    checkOutput("release_no_valid", valid_cnt, 2);

    // Press bounce lasting a single sample.
    wait_col(col_tab[2], "bounce_reach_col2");
    applyStimulus(16'h0040);
    next_sample();
    checkOutput("bounce_col_frozen", col, col_tab[2]);
    applyStimulus(16'h0000);
    next_sample();
    checkOutput("bounce_col_resume", col, col_tab[3]);
    checkOutput("bounce_no_valid", valid_cnt, 2);
    next_sample();
    checkOutput("bounce_col_wrap", col, col_tab[0]);

    // Reset in the middle of debouncing a held key.
    wait_col(col_tab[2], "rst_reach_col2");
    applyStimulus(16'h0040);
    next_sample();
    next_sample();
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_async_col", col, 4'b1110);
    checkOutput("rst_async_code", key_code, 0);
    checkOutput("rst_async_valid", key_valid, 0);
    checkOutput("rst_async_held", key_held, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rst_release_col", col, 4'b1110);
    repeat (4) next_sample();
    checkOutput("rst_no_early_valid", valid_cnt, 2);
    checkOutput("rst_no_early_held", key_held, 0);
    next_sample();
    checkOutput("rst_redebounce_valid", key_valid, 1);
    checkOutput("rst_redebounce_code", key_code, 6);
    checkOutput("rst_valid_count", valid_cnt, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
